// File: rtl/cpu2core_mem_arbiter.sv
// Two-master Avalon-MM arbiter that shares one single-port byte-enabled RAM between both cores.
// One access is granted per cycle, and read data returns to the issuing master one cycle later.

module cpu2core_mem_arbiter_chk (
  input logic clk,
  input logic reset_n,
  input logic m0_read,
  input logic m0_write,
  input logic m1_read,
  input logic m1_write
);

  // Reads issued together with a write are silently dropped, so report them.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(m0_read && m0_write)) else $error("m0 read and write asserted together");
      assert (!(m1_read && m1_write)) else $error("m1 read and write asserted together");
    end
  end

endmodule

module cpu2core_mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  output logic                m0_waitrequest,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic                m1_waitrequest,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [15:0]         gnt_cnt0,
  output logic [15:0]         gnt_cnt1
);

  localparam int BE_W = DATA_W / 8;

  logic              ready_r;
  logic              rr_ptr_r;
  logic              rsp_valid_r;
  logic              rsp_owner_r;
  logic [15:0]       gnt_cnt0_r;
  logic [15:0]       gnt_cnt1_r;
  logic [ADDR_W-1:0] last_addr_r;
  logic [BE_W-1:0]   last_be_r;
  logic [DATA_W-1:0] last_wdata_r;

  logic              m0_req_s;
  logic              m1_req_s;
  logic              gnt0_s;
  logic              gnt1_s;
  logic              gnt_any_s;
  logic              win_id_s;
  logic              win_write_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [BE_W-1:0]   win_be_s;
  logic [DATA_W-1:0] win_wdata_s;

  assign m0_req_s  = m0_read | m0_write;
  assign m1_req_s  = m1_read | m1_write;
  assign gnt_any_s = gnt0_s | gnt1_s;
  assign win_id_s  = gnt1_s;

  // Grant selection; nothing is granted before ready or while reset is applied.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (ready_r && reset_n) begin
      if (ARB_MODE != 32'sd0) begin
        gnt0_s = m0_req_s;
        gnt1_s = m1_req_s & ~m0_req_s;
      end else if (m0_req_s && m1_req_s) begin
        gnt0_s = ~rr_ptr_r;
        gnt1_s = rr_ptr_r;
      end else begin
        gnt0_s = m0_req_s;
        gnt1_s = m1_req_s;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Winner mux; a master asserting read and write together is treated as a write.
  always_comb begin
    win_write_s = m0_write;
    win_addr_s  = m0_address;
    win_be_s    = m0_byteenable;
    win_wdata_s = m0_writedata;
    if (gnt1_s) begin
      win_write_s = m1_write;
      win_addr_s  = m1_address;
      win_be_s    = m1_byteenable;
      win_wdata_s = m1_writedata;
    end else begin
      win_write_s = m0_write;
      win_addr_s  = m0_address;
      win_be_s    = m0_byteenable;
      win_wdata_s = m0_writedata;
    end
  end

  // Arbiter state, response pipeline, grant counters and held memory fields.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ready_r      <= 1'b0;
      rr_ptr_r     <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_owner_r  <= 1'b0;
      gnt_cnt0_r   <= 16'h0000;
      gnt_cnt1_r   <= 16'h0000;
      last_addr_r  <= '0;
      last_be_r    <= '0;
      last_wdata_r <= '0;
    end else begin
      ready_r     <= 1'b1;
      rsp_valid_r <= gnt_any_s & ~win_write_s;
      if (gnt_any_s) begin
        rr_ptr_r     <= ~win_id_s;
        last_addr_r  <= win_addr_s;
        last_be_r    <= win_be_s;
        last_wdata_r <= win_wdata_s;
        if (!win_write_s) begin
          rsp_owner_r <= win_id_s;
        end
      end
      if (gnt0_s) begin
        gnt_cnt0_r <= gnt_cnt0_r + 16'h0001;
      end
      if (gnt1_s) begin
        gnt_cnt1_r <= gnt_cnt1_r + 16'h0001;
      end
    end
  end

  assign m0_waitrequest   = ~gnt0_s;
  assign m1_waitrequest   = ~gnt1_s;
  // A response still in flight when reset arrives is suppressed, never delivered.
  assign m0_readdatavalid = rsp_valid_r & ~rsp_owner_r & reset_n;
  assign m1_readdatavalid = rsp_valid_r & rsp_owner_r & reset_n;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

  assign mem_chipselect = gnt_any_s;
  assign mem_write      = gnt_any_s & win_write_s;
  assign mem_address    = gnt_any_s ? win_addr_s  : last_addr_r;
  assign mem_byteenable = gnt_any_s ? win_be_s    : last_be_r;
  assign mem_writedata  = gnt_any_s ? win_wdata_s : last_wdata_r;
  assign mem_clken      = ready_r;
  assign gnt_cnt0       = gnt_cnt0_r;
  assign gnt_cnt1       = gnt_cnt1_r;

  cpu2core_mem_arbiter_chk u_chk (
    .clk      (clk),
    .reset_n  (reset_n),
    .m0_read  (m0_read),
    .m0_write (m0_write),
    .m1_read  (m1_read),
    .m1_write (m1_write)
  );

endmodule
